// File: rtl/rt_pkg.sv
// Shared types and helpers for the raytracer voxel-traversal blocks.
//   axis_e          : axis encoding, AXIS_NONE marks "no advance yet"
//   stepper_state_e : voxel_stepper control states
//   sat_add         : unsigned add clamped to 2**w-1 (w <= SatAddMaxW)
package rt_pkg;

    typedef enum logic [1:0] {
        AXIS_X    = 2'd0,
        AXIS_Y    = 2'd1,
        AXIS_Z    = 2'd2,
        AXIS_NONE = 2'd3
    } axis_e;

    typedef enum logic [1:0] {
        StIdle,
        StQuery,
        StWait,
        StDone
    } stepper_state_e;

    localparam int unsigned SatAddMaxW = 63;

    // Operands are zero-extended into 64 bits by the caller; the result fits in w bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim) begin
            return lim[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/voxel_stepper_axis_choose.sv
// axis_choose: picks the axis with the smallest tMax for the next DDA advance.
// Ties resolve towards x, then y, then z.
//   tmax_x_i/y_i/z_i : current tMax per axis (unsigned, W bits)
//   primary_sel_o    : selected axis (AXIS_X/AXIS_Y/AXIS_Z; never AXIS_NONE)
module axis_choose
    import rt_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] tmax_x_i,
    input  logic [W-1:0] tmax_y_i,
    input  logic [W-1:0] tmax_z_i,
    output logic [1:0]   primary_sel_o
);

    always_comb begin
        primary_sel_o = AXIS_Z;
        if ((tmax_x_i <= tmax_y_i) && (tmax_x_i <= tmax_z_i)) begin
            primary_sel_o = AXIS_X;
        end else if (tmax_y_i <= tmax_z_i) begin
            primary_sel_o = AXIS_Y;
        end
    end

endmodule

// File: rtl/voxel_stepper.sv
// voxel_stepper: 3D DDA voxel-traversal engine.
// Accepts one ray setup, then alternates an occupancy query (QUERY) with waiting for the
// response (WAIT). On a miss the smallest-tMax axis is advanced. The ray ends on the first
// solid voxel, on leaving the grid (detected before any coordinate would wrap), or after
// MAX_STEPS advances.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   start_*                     : ray setup handshake (valid/ready) and start voxel
//   dir_neg_i                   : per-axis step direction, [0]=x [1]=y [2]=z, 1 = -1
//   tmax_*_i / tdelta_*_i       : initial tMax and tDelta per axis
//   occ_req_valid_o, occ_*_o    : one-cycle occupancy query strobe and queried voxel
//   occ_rsp_valid_i, occ_hit_i  : occupancy response, only honoured in WAIT
//   res_*                       : result handshake and fields, held stable in DONE
module voxel_stepper
    import rt_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter int unsigned COORD_W   = 5,
    parameter int unsigned MAX_STEPS = 96,
    parameter int unsigned STEP_W    = $clog2(MAX_STEPS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               start_valid_i,
    output logic               start_ready_o,
    input  logic [COORD_W-1:0] start_x_i,
    input  logic [COORD_W-1:0] start_y_i,
    input  logic [COORD_W-1:0] start_z_i,
    input  logic [2:0]         dir_neg_i,
    input  logic [W-1:0]       tmax_x_i,
    input  logic [W-1:0]       tmax_y_i,
    input  logic [W-1:0]       tmax_z_i,
    input  logic [W-1:0]       tdelta_x_i,
    input  logic [W-1:0]       tdelta_y_i,
    input  logic [W-1:0]       tdelta_z_i,

    output logic               occ_req_valid_o,
    output logic [COORD_W-1:0] occ_x_o,
    output logic [COORD_W-1:0] occ_y_o,
    output logic [COORD_W-1:0] occ_z_o,
    input  logic               occ_rsp_valid_i,
    input  logic               occ_hit_i,

    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               res_hit_o,
    output logic               res_timeout_o,
    output logic [COORD_W-1:0] res_x_o,
    output logic [COORD_W-1:0] res_y_o,
    output logic [COORD_W-1:0] res_z_o,
    output logic [1:0]         res_axis_o,
    output logic [W-1:0]       res_t_o,
    output logic [STEP_W-1:0]  res_steps_o
);

    stepper_state_e state_q, state_d;

    // Per-axis registers, index 0 = x, 1 = y, 2 = z.
    logic [2:0][COORD_W-1:0] coord_q, coord_d;
    logic [2:0][W-1:0]       tmax_q, tmax_d;
    logic [2:0][W-1:0]       tdelta_q, tdelta_d;
    logic [2:0]              dir_q, dir_d;

    logic [W-1:0]            t_q, t_d;
    axis_e                   axis_q, axis_d;
    logic [STEP_W-1:0]       steps_q, steps_d;
    logic                    hit_q, hit_d;
    logic                    timeout_q, timeout_d;

    logic [1:0]              sel;
    logic [COORD_W-1:0]      cur_coord;
    logic [COORD_W-1:0]      coord_next;
    logic [W-1:0]            cur_tmax;
    logic [W-1:0]            cur_tdelta;
    logic [W-1:0]            tmax_next;
    logic                    cur_neg;
    logic                    at_edge;
    logic [STEP_W-1:0]       steps_inc;

    axis_choose #(
        .W(W)
    ) u_axis_choose (
        .tmax_x_i      (tmax_q[0]),
        .tmax_y_i      (tmax_q[1]),
        .tmax_z_i      (tmax_q[2]),
        .primary_sel_o (sel)
    );

    // Operands of the selected axis.
    always_comb begin
        cur_coord  = coord_q[0];
        cur_tmax   = tmax_q[0];
        cur_tdelta = tdelta_q[0];
        cur_neg    = dir_q[0];
        unique case (sel)
            2'd1: begin
                cur_coord  = coord_q[1];
                cur_tmax   = tmax_q[1];
                cur_tdelta = tdelta_q[1];
                cur_neg    = dir_q[1];
            end
            2'd2: begin
                cur_coord  = coord_q[2];
                cur_tmax   = tmax_q[2];
                cur_tdelta = tdelta_q[2];
                cur_neg    = dir_q[2];
            end
            default: ;
        endcase
    end

    // Leaving the grid is decided on the current coordinate, so the advance never wraps.
    assign at_edge    = cur_neg ? (cur_coord == '0) : (cur_coord == {COORD_W{1'b1}});
    assign coord_next = cur_neg ? (cur_coord - COORD_W'(1)) : (cur_coord + COORD_W'(1));
    assign tmax_next  = W'(sat_add(64'(cur_tmax), 64'(cur_tdelta), W));
    assign steps_inc  = steps_q + STEP_W'(1);

    always_comb begin
        state_d   = state_q;
        coord_d   = coord_q;
        tmax_d    = tmax_q;
        tdelta_d  = tdelta_q;
        dir_d     = dir_q;
        t_d       = t_q;
        axis_d    = axis_q;
        steps_d   = steps_q;
        hit_d     = hit_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid_i) begin
                    coord_d   = {start_z_i, start_y_i, start_x_i};
                    tmax_d    = {tmax_z_i, tmax_y_i, tmax_x_i};
                    tdelta_d  = {tdelta_z_i, tdelta_y_i, tdelta_x_i};
                    dir_d     = dir_neg_i;
                    t_d       = '0;
                    axis_d    = AXIS_NONE;
                    steps_d   = '0;
                    hit_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StQuery;
                end
            end

            StQuery: begin
                state_d = StWait;
            end

            StWait: begin
                if (occ_rsp_valid_i) begin
                    if (occ_hit_i) begin
                        hit_d   = 1'b1;
                        state_d = StDone;
                    end else if (at_edge) begin
                        state_d = StDone;
                    end else begin
                        for (int a = 0; a < 3; a++) begin
                            if (sel == 2'(a)) begin
                                coord_d[a] = coord_next;
                                tmax_d[a]  = tmax_next;
                            end
                        end
                        t_d     = cur_tmax;
                        axis_d  = axis_e'(sel);
                        steps_d = steps_inc;
                        if (steps_inc == STEP_W'(MAX_STEPS)) begin
                            timeout_d = 1'b1;
                            state_d   = StDone;
                        end else begin
                            state_d = StQuery;
                        end
                    end
                end
            end

            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            coord_q   <= '0;
            tmax_q    <= '0;
            tdelta_q  <= '0;
            dir_q     <= '0;
            t_q       <= '0;
            axis_q    <= AXIS_NONE;
            steps_q   <= '0;
            hit_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            coord_q   <= coord_d;
            tmax_q    <= tmax_d;
            tdelta_q  <= tdelta_d;
            dir_q     <= dir_d;
            t_q       <= t_d;
            axis_q    <= axis_d;
            steps_q   <= steps_d;
            hit_q     <= hit_d;
            timeout_q <= timeout_d;
        end
    end

    assign start_ready_o   = (state_q == StIdle);
    assign occ_req_valid_o = (state_q == StQuery);
    assign occ_x_o         = coord_q[0];
    assign occ_y_o         = coord_q[1];
    assign occ_z_o         = coord_q[2];

    assign res_valid_o     = (state_q == StDone);
    assign res_hit_o       = hit_q;
    assign res_timeout_o   = timeout_q;
    assign res_x_o         = coord_q[0];
    assign res_y_o         = coord_q[1];
    assign res_z_o         = coord_q[2];
    assign res_axis_o      = axis_q;
    assign res_t_o         = t_q;
    assign res_steps_o     = steps_q;

endmodule

// File: tb/tb_voxel_stepper.sv
// Self-checking bench for voxel_stepper (MAX_STEPS reduced to 4 so timeouts are reachable).
module tb_voxel_stepper;

    localparam int W  = 32;
    localparam int CW = 5;
    localparam int MS = 4;
    localparam int SW = $clog2(MS + 1);
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    typedef struct packed {
        logic          hit;
        logic          to;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
        logic [1:0]    axis;
        logic [W-1:0]  t;
        logic [SW-1:0] steps;
    } res_s;

    logic          clk;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] start_x, start_y, start_z;
    logic [2:0]    dir_neg;
    logic [W-1:0]  tmax_x, tmax_y, tmax_z;
    logic [W-1:0]  tdelta_x, tdelta_y, tdelta_z;
    logic          occ_req_valid;
    logic [CW-1:0] occ_x, occ_y, occ_z;
    logic          occ_rsp_valid;
    logic          occ_hit;
    logic          res_valid;
    logic          res_ready;
    logic          res_hit;
    logic          res_timeout;
    logic [CW-1:0] res_x, res_y, res_z;
    logic [1:0]    res_axis;
    logic [W-1:0]  res_t;
    logic [SW-1:0] res_steps;

    int n_cmp = 0;
    int n_fail = 0;
    int rsp_delay = 1;
    bit resp_en = 1'b0;
    logic [3*CW-1:0] solid[$];

    voxel_stepper #(
        .W(W),
        .COORD_W(CW),
        .MAX_STEPS(MS)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_valid_i  (start_valid),
        .start_ready_o  (start_ready),
        .start_x_i      (start_x),
        .start_y_i      (start_y),
        .start_z_i      (start_z),
        .dir_neg_i      (dir_neg),
        .tmax_x_i       (tmax_x),
        .tmax_y_i       (tmax_y),
        .tmax_z_i       (tmax_z),
        .tdelta_x_i     (tdelta_x),
        .tdelta_y_i     (tdelta_y),
        .tdelta_z_i     (tdelta_z),
        .occ_req_valid_o(occ_req_valid),
        .occ_x_o        (occ_x),
        .occ_y_o        (occ_y),
        .occ_z_o        (occ_z),
        .occ_rsp_valid_i(occ_rsp_valid),
        .occ_hit_i      (occ_hit),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_hit_o      (res_hit),
        .res_timeout_o  (res_timeout),
        .res_x_o        (res_x),
        .res_y_o        (res_y),
        .res_z_o        (res_z),
        .res_axis_o     (res_axis),
        .res_t_o        (res_t),
        .res_steps_o    (res_steps)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_solid(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                    input logic [CW-1:0] z);
        foreach (solid[i]) begin
            if (solid[i] == {x, y, z}) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic res_s dut_res();
        return '{hit: res_hit, to: res_timeout, x: res_x, y: res_y, z: res_z,
                 axis: res_axis, t: res_t, steps: res_steps};
    endfunction

    function automatic string fmt(input res_s r);
        return $sformatf("hit=%0d to=%0d xyz=(%0d,%0d,%0d) axis=%0d t=%0h steps=%0d",
                         r.hit, r.to, r.x, r.y, r.z, r.axis, r.t, r.steps);
    endfunction

    // Walks the ray with plain integer arithmetic; q is the number of occupancy queries.
    function automatic void model(input logic [CW-1:0] sx, input logic [CW-1:0] sy,
                                  input logic [CW-1:0] sz, input logic [2:0] dn,
                                  input logic [W-1:0] tmx, input logic [W-1:0] tmy,
                                  input logic [W-1:0] tmz, input logic [W-1:0] tdx,
                                  input logic [W-1:0] tdy, input logic [W-1:0] tdz,
                                  output res_s e, output int q);
        longint tm[3];
        longint td[3];
        int     c[3];
        int     s;
        int     steps;
        int     ax;
        longint t;
        bit     hit;
        bit     to;
        tm = '{longint'(tmx), longint'(tmy), longint'(tmz)};
        td = '{longint'(tdx), longint'(tdy), longint'(tdz)};
        c  = '{int'(sx), int'(sy), int'(sz)};
        steps = 0; ax = 3; t = 0; hit = 0; to = 0; q = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            q++;
            if (is_solid(CW'(c[0]), CW'(c[1]), CW'(c[2]))) begin
                hit = 1;
                break;
            end
            s = 0;
            if (tm[1] < tm[s]) s = 1;
            if (tm[2] < tm[s]) s = 2;
            if ((dn[s] && c[s] == 0) || (!dn[s] && c[s] == (1 << CW) - 1)) break;
            c[s] = dn[s] ? c[s] - 1 : c[s] + 1;
            t = tm[s];
            tm[s] = (tm[s] + td[s] > MAXV) ? MAXV : tm[s] + td[s];
            ax = s;
            steps++;
            if (steps == MS) begin
                to = 1;
                break;
            end
        end
        e = '{hit: hit, to: to, x: CW'(c[0]), y: CW'(c[1]), z: CW'(c[2]), axis: 2'(ax),
              t: W'(t), steps: SW'(steps)};
    endfunction

    // Occupancy store: answers each query rsp_delay cycles into WAIT, checking that the
    // queried voxel is held steady meanwhile.
    initial begin
        logic [3*CW-1:0] qv;
        occ_rsp_valid = 1'b0;
        occ_hit = 1'b0;
        forever begin
            @(posedge clk); #1;
            while (resp_en && occ_req_valid) begin
                qv = {occ_x, occ_y, occ_z};
                @(posedge clk); #1;
                for (int i = 0; i < rsp_delay; i++) begin
                    n_cmp++;
                    if ({occ_req_valid, occ_x, occ_y, occ_z} !== {1'b0, qv}) begin
                        n_fail++;
                        $display("FAIL occ_hold: got req=%0d (%0d,%0d,%0d) want req=0 (%0d,%0d,%0d)",
                                 occ_req_valid, occ_x, occ_y, occ_z,
                                 qv[14:10], qv[9:5], qv[4:0]);
                    end
                    if (i == rsp_delay - 1) begin
                        occ_rsp_valid = 1'b1;
                        occ_hit = is_solid(qv[14:10], qv[9:5], qv[4:0]);
                    end
                    @(posedge clk); #1;
                end
                occ_rsp_valid = 1'b0;
                occ_hit = 1'b0;
            end
        end
    end

    // Drives one ray and collects the result; lat = edges from handshake to res_valid.
    task automatic do_ray(input logic [CW-1:0] sx, input logic [CW-1:0] sy,
                          input logic [CW-1:0] sz, input logic [2:0] dn,
                          input logic [W-1:0] tmx, input logic [W-1:0] tmy,
                          input logic [W-1:0] tmz, input logic [W-1:0] tdx,
                          input logic [W-1:0] tdy, input logic [W-1:0] tdz,
                          input int hold, output res_s got, output int lat, output bit stable);
        int guard;
        guard = 0;
        while (!start_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!start_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL start_ready_wait: got 0 want 1 within 100 cycles");
        end
        start_valid = 1'b1;
        start_x = sx; start_y = sy; start_z = sz; dir_neg = dn;
        tmax_x = tmx; tmax_y = tmy; tmax_z = tmz;
        tdelta_x = tdx; tdelta_y = tdy; tdelta_z = tdz;
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL res_valid_wait: got 0 want 1 within 2000 cycles");
        end
        got = dut_res();
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!res_valid || dut_res() !== got) stable = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        res_s exp;
        exp = '0;
        exp.axis = 2'd3;
        n_cmp++;
        if ({start_ready, occ_req_valid, res_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_handshake: got rdy/req/vld=%b want 100",
                     {start_ready, occ_req_valid, res_valid});
        end
        n_cmp++;
        if (dut_res() !== exp) begin
            n_fail++;
            $display("FAIL reset_result: got %s want %s", fmt(dut_res()), fmt(exp));
        end
        n_cmp++;
        if ({occ_x, occ_y, occ_z} !== '0) begin
            n_fail++;
            $display("FAIL reset_occ: got (%0d,%0d,%0d) want (0,0,0)", occ_x, occ_y, occ_z);
        end
    endtask

    task automatic test_start_hit();
        res_s got, exp;
        int lat;
        bit st;
        solid = '{{5'd9, 5'd9, 5'd9}};
        rsp_delay = 1;
        do_ray(5'd9, 5'd9, 5'd9, 3'b000, 7, 8, 9, 1, 1, 1, 0, got, lat, st);
        exp = '{hit: 1'b1, to: 1'b0, x: 5'd9, y: 5'd9, z: 5'd9, axis: 2'd3, t: '0, steps: '0};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL start_hit: got %s want %s", fmt(got), fmt(exp));
        end
        // QUERY, WAIT, then DONE visible: two edges after the handshake edge.
        n_cmp++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL start_hit_latency: got %0d want 2", lat);
        end
    endtask

    task automatic test_tie_hit();
        res_s got, exp;
        int lat;
        bit st;
        solid = '{{5'd5, 5'd4, 5'd4}};
        rsp_delay = 1;
        do_ray(5'd4, 5'd4, 5'd4, 3'b000, 10, 10, 10, 10, 10, 10, 0, got, lat, st);
        exp = '{hit: 1'b1, to: 1'b0, x: 5'd5, y: 5'd4, z: 5'd4, axis: 2'd0, t: 32'd10,
                steps: 3'd1};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL tie_hit: got %s want %s", fmt(got), fmt(exp));
        end
        n_cmp++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL tie_hit_latency: got %0d want 4", lat);
        end
    endtask

    task automatic test_exit_edge();
        res_s got, exp;
        int lat;
        bit st;
        solid.delete();
        rsp_delay = 1;
        do_ray(5'd0, 5'd7, 5'd7, 3'b001, 1, 5, 9, 3, 3, 3, 0, got, lat, st);
        exp = '{hit: 1'b0, to: 1'b0, x: 5'd0, y: 5'd7, z: 5'd7, axis: 2'd3, t: '0, steps: '0};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL exit_edge: got %s want %s", fmt(got), fmt(exp));
        end
        // Positive direction at the top boundary: y is smallest at 31.
        do_ray(5'd3, 5'd31, 5'd3, 3'b000, 9, 2, 9, 3, 3, 3, 0, got, lat, st);
        exp = '{hit: 1'b0, to: 1'b0, x: 5'd3, y: 5'd31, z: 5'd3, axis: 2'd3, t: '0, steps: '0};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL exit_edge_high: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_timeout();
        res_s got, exp;
        int lat;
        bit st;
        solid.delete();
        rsp_delay = 1;
        do_ray(5'd0, 5'd0, 5'd0, 3'b000, 10, 10, 10, 10, 10, 10, 0, got, lat, st);
        exp = '{hit: 1'b0, to: 1'b1, x: 5'd2, y: 5'd1, z: 5'd1, axis: 2'd0, t: 32'd20,
                steps: 3'd4};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL timeout: got %s want %s", fmt(got), fmt(exp));
        end
        n_cmp++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d want 8", lat);
        end
    endtask

    task automatic test_saturation();
        res_s got, exp;
        int lat;
        bit st;
        solid.delete();
        rsp_delay = 1;
        // y steps once, its tMax clamps at 2**W-1; a wrapped tMax would pick y again.
        do_ray(5'd10, 5'd10, 5'd10, 3'b000, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 32'hFFFF_FFFC,
               1, 100, 1, 0, got, lat, st);
        exp = '{hit: 1'b0, to: 1'b1, x: 5'd13, y: 5'd11, z: 5'd10, axis: 2'd0,
                t: 32'hFFFF_FFFA, steps: 3'd4};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL saturation: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_backpressure();
        res_s got, exp;
        int lat;
        bit st;
        solid = '{{5'd5, 5'd5, 5'd4}};
        rsp_delay = 5;
        do_ray(5'd4, 5'd4, 5'd4, 3'b000, 10, 10, 10, 10, 10, 10, 3, got, lat, st);
        exp = '{hit: 1'b1, to: 1'b0, x: 5'd5, y: 5'd5, z: 5'd4, axis: 2'd1, t: 32'd10,
                steps: 3'd2};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL backpressure: got %s want %s", fmt(got), fmt(exp));
        end
        n_cmp++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL backpressure_latency: got %0d want 18", lat);
        end
        n_cmp++;
        if (st !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_hold: got stable=%0d want 1", st);
        end
        n_cmp++;
        if ({start_ready, res_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL after_accept: got rdy/vld=%b want 10", {start_ready, res_valid});
        end
        rsp_delay = 1;
    endtask

    task automatic test_reset_in_wait();
        res_s got, exp, rexp;
        int lat, q;
        bit st;
        resp_en = 1'b0;
        solid.delete();
        start_valid = 1'b1;
        start_x = 5'd4; start_y = 5'd6; start_z = 5'd8; dir_neg = 3'b010;
        tmax_x = 3; tmax_y = 4; tmax_z = 5; tdelta_x = 1; tdelta_y = 1; tdelta_z = 1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        n_cmp++;
        if ({occ_req_valid, occ_x, occ_y, occ_z} !== {1'b1, 5'd4, 5'd6, 5'd8}) begin
            n_fail++;
            $display("FAIL query_strobe: got req=%0d (%0d,%0d,%0d) want req=1 (4,6,8)",
                     occ_req_valid, occ_x, occ_y, occ_z);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rexp = '0;
        rexp.axis = 2'd3;
        n_cmp++;
        if ({start_ready, occ_req_valid, res_valid, occ_x, occ_y, occ_z} !==
            {3'b100, 15'd0} || dut_res() !== rexp) begin
            n_fail++;
            $display("FAIL reset_in_wait: got rdy/req/vld=%b %s want 100 %s",
                     {start_ready, occ_req_valid, res_valid}, fmt(dut_res()), fmt(rexp));
        end
        // Stray response while idle must not start or finish anything.
        occ_rsp_valid = 1'b1;
        occ_hit = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        occ_rsp_valid = 1'b0;
        occ_hit = 1'b0;
        n_cmp++;
        if ({start_ready, occ_req_valid, res_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL spurious_rsp: got rdy/req/vld=%b want 100",
                     {start_ready, occ_req_valid, res_valid});
        end
        resp_en = 1'b1;
        solid = '{{5'd5, 5'd6, 5'd8}};
        do_ray(5'd4, 5'd6, 5'd8, 3'b010, 3, 4, 5, 1, 1, 1, 0, got, lat, st);
        model(5'd4, 5'd6, 5'd8, 3'b010, 3, 4, 5, 1, 1, 1, exp, q);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ray_after_reset: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    function automatic logic [CW-1:0] pick_coord();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return CW'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        res_s got, exp;
        int lat, q, hold, n;
        bit st;
        logic [CW-1:0] sx, sy, sz;
        logic [2:0] dn;
        logic [W-1:0] tm[3];
        logic [W-1:0] td[3];
        for (int k = 0; k < 40; k++) begin
            sx = pick_coord(); sy = pick_coord(); sz = pick_coord();
            dn = 3'($urandom_range(0, 7));
            for (int a = 0; a < 3; a++) begin
                tm[a] = W'($urandom_range(1, 40));
                td[a] = W'($urandom_range(1, 40));
            end
            if (k % 8 == 0) begin
                tm[1] = W'(32'hFFFF_FFFF - $urandom_range(0, 60));
                td[1] = W'($urandom_range(1, 200));
                tm[0] = W'(32'hFFFF_FFF0 - $urandom_range(0, 30));
                tm[2] = W'(32'hFFFF_FFF0 - $urandom_range(0, 30));
            end
            solid.delete();
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                solid.push_back({CW'(sx + CW'($urandom_range(0, 4)) - CW'(2)),
                                 CW'(sy + CW'($urandom_range(0, 4)) - CW'(2)),
                                 CW'(sz + CW'($urandom_range(0, 4)) - CW'(2))});
            end
            rsp_delay = $urandom_range(1, 3);
            hold = $urandom_range(0, 2);
            model(sx, sy, sz, dn, tm[0], tm[1], tm[2], td[0], td[1], td[2], exp, q);
            do_ray(sx, sy, sz, dn, tm[0], tm[1], tm[2], td[0], td[1], td[2], hold,
                   got, lat, st);
            n_cmp++;
            if (got !== exp || st !== 1'b1) begin
                n_fail++;
                $display("FAIL random[%0d]: got %s stable=%0d want %s stable=1",
                         k, fmt(got), st, fmt(exp));
            end
            n_cmp++;
            if (lat !== q * (1 + rsp_delay)) begin
                n_fail++;
                $display("FAIL random_latency[%0d]: got %0d want %0d", k, lat,
                         q * (1 + rsp_delay));
            end
        end
        rsp_delay = 1;
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        start_x = '0; start_y = '0; start_z = '0; dir_neg = '0;
        tmax_x = '0; tmax_y = '0; tmax_z = '0;
        tdelta_x = '0; tdelta_y = '0; tdelta_z = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        resp_en = 1'b1;
        test_reset();
        test_start_hit();
        test_tie_hit();
        test_exit_edge();
        test_timeout();
        test_saturation();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
